// File: rtl/seg_scan_driver_pkg.sv
// Shared types and defaults for the multiplexed seven-segment scan driver.
package seg_scan_driver_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    LIT   = 1'b1
  } scan_state_t;

  localparam int DIGIT_CYCLES_DEF = 50000;
  localparam int BLANK_CYCLES_DEF = 8;
  localparam int NUM_DIGITS_MIN   = 2;
  localparam int NUM_DIGITS_MAX   = 8;

  function automatic bit num_digits_ok(input int n);
    return (n >= NUM_DIGITS_MIN) && (n <= NUM_DIGITS_MAX);
  endfunction

endpackage

// File: rtl/seg_scan_driver_lz_mask.sv
// Leading-zero suppress mask: bit k set when digit k and every digit above it are zero.
module scan_lz_mask
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   mask
);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_mask
      if (gi == 0) begin : g_units
        // The rightmost digit always lights so a zero value still shows "0".
        assign mask[gi] = 1'b0;
      end else begin : g_upper
        assign mask[gi] = lz_suppress && (value[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex scan controller for a common-anode display, with
// blanking between digits, frame-aligned value update and leading-zero blanking.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = DIGIT_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic                    enable,
  output logic [3:0]              digit_nibble,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_tick,
  output logic                    update_pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  generate
    if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_num_digits
      $error("seg_scan_driver: NUM_DIGITS out of range 2..8");
    end
  endgenerate

  scan_state_t                 state_reg;
  logic [CNT_W-1:0]            cnt_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic [4*NUM_DIGITS-1:0]     disp_reg;
  logic [4*NUM_DIGITS-1:0]     pend_reg;
  logic                        upd_reg;
  logic                        tick_reg;
  logic [NUM_DIGITS-1:0]       anodes_reg;
  logic [3:0]                  nibble_reg;

  logic                        xfer;
  logic [4*NUM_DIGITS-1:0]     disp_next;
  logic [NUM_DIGITS-1:0]       supp_mask;
  logic [3:0]                  digits_next [NUM_DIGITS];
  logic [IDX_W-1:0]            idx_adv;
  logic                        last_idx;
  logic [NUM_DIGITS-1:0]       sel_onehot;
  logic                        anode_off;
  logic [NUM_DIGITS-1:0]       lit_anodes;

  // The transfer lands at the end of the frame_tick cycle, which is always a
  // blank cycle, so no digit is ever lit from a half-updated value.
  assign xfer      = tick_reg && upd_reg;
  assign disp_next = xfer ? pend_reg : disp_reg;

  scan_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .value       (disp_next),
    .lz_suppress (lz_suppress),
    .mask        (supp_mask)
  );

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
      assign digits_next[gi] = disp_next[4*gi +: 4];
    end
  endgenerate

  assign last_idx   = (idx_reg == IDX_LAST);
  assign idx_adv    = last_idx ? '0 : idx_reg + IDX_W'(1);
  assign sel_onehot = NUM_DIGITS'(1) << idx_reg;
  assign anode_off  = !enable || supp_mask[idx_reg];
  assign lit_anodes = ~sel_onehot | {NUM_DIGITS{anode_off}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= BLANK;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      upd_reg    <= 1'b0;
      tick_reg   <= 1'b0;
      anodes_reg <= '1;
      nibble_reg <= 4'h0;
    end else begin
      tick_reg <= 1'b0;
      disp_reg <= disp_next;
      if (load) begin
        pend_reg <= value;
        upd_reg  <= 1'b1;
      end else if (xfer) begin
        upd_reg <= 1'b0;
      end

      case (state_reg)
        BLANK: begin
          // Keep the nibble tracking the (possibly just transferred) value so
          // the decoder has settled before the anode turns on.
          nibble_reg <= digits_next[idx_reg];
          if (cnt_reg == BLANK_LAST) begin
            state_reg  <= LIT;
            cnt_reg    <= '0;
            anodes_reg <= lit_anodes;
          end else begin
            cnt_reg    <= cnt_reg + CNT_W'(1);
            anodes_reg <= '1;
          end
        end
        LIT: begin
          if (cnt_reg == DIGIT_LAST) begin
            state_reg  <= BLANK;
            cnt_reg    <= '0;
            idx_reg    <= idx_adv;
            anodes_reg <= '1;
            nibble_reg <= digits_next[idx_adv];
            tick_reg   <= last_idx;
          end else begin
            cnt_reg    <= cnt_reg + CNT_W'(1);
            anodes_reg <= lit_anodes;
          end
        end
        default: begin
          state_reg  <= BLANK;
          cnt_reg    <= '0;
          anodes_reg <= '1;
        end
      endcase
    end
  end

  assign digit_nibble   = nibble_reg;
  assign anodes         = anodes_reg;
  assign frame_tick     = tick_reg;
  assign update_pending = upd_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic, checked
// every cycle against a time-based reference model of the scan.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int DC = 4;
  localparam int BC = 2;
  localparam int SLOT = DC + BC;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value = '0;
  logic          load = 1'b0;
  logic          lz_suppress = 1'b0;
  logic          enable = 1'b1;
  logic [3:0]    digit_nibble;
  logic [ND-1:0] anodes;
  logic          frame_tick;
  logic          update_pending;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles since reset plus the value registers as the user sees them.
  int          m_t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_upd = 1'b0;
  bit          m_en = 1'b1;
  bit          m_lz = 1'b0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS   (ND),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC),
    .CNT_W        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .value          (value),
    .load           (load),
    .lz_suppress    (lz_suppress),
    .enable         (enable),
    .digit_nibble   (digit_nibble),
    .anodes         (anodes),
    .frame_tick     (frame_tick),
    .update_pending (update_pending)
  );

  function automatic bit model_tick(input int t);
    return (t > 0) && (t % FRAME == 0);
  endfunction

  function automatic bit suppressed(input int k, input logic [15:0] v, input bit lz);
    return lz && (k > 0) && ((v >> (4 * k)) == 16'h0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit tick_now;
    tick_now = model_tick(m_t);
    if (rst) begin
      m_t = 0; m_disp = '0; m_pend = '0; m_upd = 1'b0;
    end else begin
      if (tick_now && m_upd) begin
        m_disp = m_pend;
        m_upd  = 1'b0;
      end
      if (load) begin
        m_pend = value;
        m_upd  = 1'b1;
      end
      m_t++;
    end
    m_en = enable;
    m_lz = lz_suppress;
  endtask

  task automatic check_outputs();
    int pos, d, w;
    logic [3:0] exp_an;
    logic [15:0] sh;
    pos = m_t % FRAME;
    d = pos / SLOT;
    w = pos % SLOT;
    exp_an = 4'hF;
    if (w >= BC && m_en && !suppressed(d, m_disp, m_lz)) exp_an[d] = 1'b0;
    chk("anodes", 32'(anodes), 32'(exp_an));
    chk("frame_tick", 32'(frame_tick), 32'(model_tick(m_t)));
    chk("update_pending", 32'(update_pending), 32'(m_upd));
    chk("one_anode_max", 32'($countones(~anodes) <= 1), 32'd1);
    if (w >= 1 || m_t == 0) begin
      sh = m_disp >> (4 * d);
      chk("digit_nibble", 32'(digit_nibble), 32'(sh[3:0]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    bit found;
    // Reset and first value
    run(3);
    rst = 1'b0;
    pulse_load(16'h1234);
    run(60);

    // Last load before the tick wins
    pulse_load(16'hABCD);
    run(5);
    pulse_load(16'h5678);
    run(50);

    // Load exactly on the frame_tick cycle
    found = 1'b0;
    pulse_load(16'h0F1E);
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      cycle();
      if (model_tick(m_t)) found = 1'b1;
    end
    chk("tick_found", 32'(found), 32'd1);
    pulse_load(16'h9A0C);
    run(2 * FRAME + 5);

    // Leading-zero suppression
    lz_suppress = 1'b1;
    pulse_load(16'h0070);
    run(2 * FRAME);
    pulse_load(16'h0000);
    run(2 * FRAME);
    lz_suppress = 1'b0;

    // Anodes gated off for a full frame, scan keeps running
    enable = 1'b0;
    run(FRAME + 6);
    enable = 1'b1;
    run(10);

    // Reset in the middle of digit 2's lit window
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      cycle();
      if ((m_t % FRAME) / SLOT == 2 && (m_t % SLOT) == BC + 1) found = 1'b1;
    end
    chk("lit_digit2_found", 32'(found), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(FRAME + 4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 15) == 0) || (model_tick(m_t) && $urandom_range(0, 1) == 1);
      value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 31) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) lz_suppress = ~lz_suppress;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    load = 1'b0;
    rst = 1'b0;
    run(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
